// File: rtl/uart_tx_msg.sv
// uart_tx_msg: UART transmitter for a fixed multi-character message.
// Sends MSG (leftmost character first, data bits LSB first) with a
// BAUDRATE-cycle bit period. After the message it holds the line idle for
// GAP_CYCLES cycles, then pulses done. MODE 0 sends one message per start
// request. MODE 1 repeats the message while start stays high.
// Optional feature: define UART_TX_MSG_PARITY_EN to add an even-parity bit
// after data bit 7, giving an 8E1 frame instead of 8N1.
module uart_tx_msg #(
  parameter int                   BAUDRATE   = 104,
  parameter int                   MSG_LEN    = 4,
  parameter logic [8*MSG_LEN-1:0] MSG        = "HOLA",
  parameter int                   MODE       = 0,
  parameter int                   GAP_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  output logic                           tx,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MSG_LEN+1)-1:0]   char_idx
);

  localparam int IDXW    = $clog2(MSG_LEN + 1);
  localparam int CNT_MAX = (BAUDRATE > GAP_CYCLES) ? BAUDRATE : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0]   GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_MSG_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      char_q, char_d;
  logic [IDXW-1:0] char_idx_q, char_idx_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            armed_q, armed_d;
  logic            bit_end;
  logic            finish;

  // Character k of the message, with the leftmost character at k = 0.
  function automatic logic [7:0] msg_char(input logic [IDXW-1:0] k);
    logic [8*MSG_LEN-1:0] s;
    s = MSG << (8 * k);
    return s[8*MSG_LEN-1 -: 8];
  endfunction

  assign bit_end = (cnt_q == BAUD_LAST);

  // Next-state logic. tx_d holds the level of the bit being entered, so the
  // registered tx output changes on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    char_d     = char_q;
    char_idx_d = char_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    armed_d    = armed_q;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start && armed_q) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          char_idx_d = '0;
          char_d     = msg_char('0);
          cnt_d      = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = char_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_MSG_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^char_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = char_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_MSG_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // The NEXT decision takes no cycle: the next start bit or the gap
          // begins immediately after the stop bit.
          cnt_d = '0;
          if (char_idx_q < IDX_LAST) begin
            char_idx_d = char_idx_q + IDXW'(1);
            char_d     = msg_char(char_idx_q + IDXW'(1));
            state_d    = S_START;
            tx_d       = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            tx_d    = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // End of the message including the gap. It comes either from the gap
    // counter or, with no gap, directly from the last stop bit.
    if (finish) begin
      done_d     = 1'b1;
      char_idx_d = '0;
      cnt_d      = '0;
      bit_d      = '0;
      if (MODE != 0 && start) begin
        state_d = S_START;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        char_d  = msg_char('0);
      end else begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end

    if (MODE != 0) begin
      armed_d = 1'b1;
    end else begin
      if (finish) armed_d = 1'b0;
      if (!start) armed_d = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      char_q     <= '0;
      char_idx_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      char_q     <= char_d;
      char_idx_q <= char_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = char_idx_q;

endmodule

// File: tb/tb_uart_tx_msg.sv
// Bench for uart_tx_msg. Three instances are used: MODE 0 "Hk", MODE 1 "Hk",
// and MODE 0 "A" with no gap. Stimulus pushes the expected frames and done
// times into queues. Monitors decode the serial line and watch done on the
// selected instance.
module tb_uart_tx_msg;

`ifdef UART_TX_MSG_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int BAUD = 4;
  localparam int GAP  = 8;
  localparam int MSGT = 2 * F * BAUD + GAP;

  typedef struct {
    logic [7:0] b;
    int         idx;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn01, rstn2;
  logic [2:0] start_v;
  logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  logic [1:0] cidx0, cidx1;
  logic [0:0] cidx2;

  int   sel;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t bq[$];
  int   dq[$];

  logic tx_sel, busy_sel, done_sel;
  int   cidx_sel;

  uart_tx_msg #(.BAUDRATE(BAUD), .MSG_LEN(2), .MSG("Hk"), .MODE(0), .GAP_CYCLES(GAP)) u0 (
    .clk(clk), .rstn(rstn01), .start(start_v[0]), .tx(tx0), .busy(busy0), .done(done0), .char_idx(cidx0));
  uart_tx_msg #(.BAUDRATE(BAUD), .MSG_LEN(2), .MSG("Hk"), .MODE(1), .GAP_CYCLES(GAP)) u1 (
    .clk(clk), .rstn(rstn01), .start(start_v[1]), .tx(tx1), .busy(busy1), .done(done1), .char_idx(cidx1));
  uart_tx_msg #(.BAUDRATE(BAUD), .MSG_LEN(1), .MSG("A"), .MODE(0), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rstn(rstn2), .start(start_v[2]), .tx(tx2), .busy(busy2), .done(done2), .char_idx(cidx2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (sel)
      1:       begin tx_sel = tx1; busy_sel = busy1; done_sel = done1; cidx_sel = int'(cidx1); end
      2:       begin tx_sel = tx2; busy_sel = busy2; done_sel = done2; cidx_sel = int'(cidx2); end
      default: begin tx_sel = tx0; busy_sel = busy0; done_sel = done0; cidx_sel = int'(cidx0); end
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count busy and done cycles over n negedges. Start on the selected
  // instance drops after iteration drop_at.
  task automatic run(input int n, input int drop_at, output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_sel) bc++;
      if (done_sel) dc++;
      if (i == drop_at) start_v[sel] = 1'b0;
    end
  endtask

  logic [7:0] mon_d;
  int         mon_idx;
  logic       mon_p, mon_s;
  exp_t       mon_e;

  // Frame decoder: sample each bit in its second cycle
  always begin : byte_mon
    @(negedge clk);
    if (tx_sel === 1'b0) begin
      mon_idx = cidx_sel;
      mon_p   = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        mon_d[i] = tx_sel;
      end
`ifdef UART_TX_MSG_PARITY_EN
      repeat (BAUD) @(negedge clk);
      mon_p = tx_sel;
`endif
      repeat (BAUD) @(negedge clk);
      mon_s = tx_sel;
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got 0x%02h expected none", mon_d);
      end else begin
        mon_e = bq.pop_front();
        chk("frame_byte", int'(mon_d), int'(mon_e.b));
        chk("frame_char_idx", mon_idx, mon_e.idx);
`ifdef UART_TX_MSG_PARITY_EN
        chk("frame_parity", int'(mon_p), int'(mon_e.par));
`endif
        chk("frame_stop", int'(mon_s), 1);
      end
    end
  end

  // Done monitor: compare each pulse against the expected cycle
  always begin : done_mon
    @(negedge clk);
    if (done_sel === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got cycle %0d expected none", cyc);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  int bc, dc, c;

  initial begin
    rstn01  = 1'b0;
    rstn2   = 1'b0;
    start_v = '0;
    sel     = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_char_idx", int'(cidx0), 0);
    rstn01 = 1'b1;
    rstn2  = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a frame on u2
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (20) @(negedge clk);
    chk("midframe_busy", int'(busy2), 1);
    #1 rstn2 = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx2), 1);
    chk("async_rst_busy", int'(busy2), 0);
    chk("async_rst_done", int'(done2), 0);
    chk("async_rst_char_idx", int'(cidx2), 0);
    @(negedge clk);
    rstn2 = 1'b1;
    @(negedge clk);

    // MODE 0: single-cycle start pulse
    sel = 0;
    bq.push_back('{8'h48, 0, 1'b0});
    bq.push_back('{8'h6B, 1, 1'b1});
    dq.push_back(cyc + 1 + MSGT);
    start_v[0] = 1'b1;
    run(100, 0, bc, dc);
    chk("pulse_busy_cycles", bc, MSGT);
    chk("pulse_done_count", dc, 1);

    // MODE 0: start held high sends only one message
    bq.push_back('{8'h48, 0, 1'b0});
    bq.push_back('{8'h6B, 1, 1'b1});
    dq.push_back(cyc + 1 + MSGT);
    start_v[0] = 1'b1;
    run(500, 499, bc, dc);
    chk("held_busy_cycles", bc, MSGT);
    chk("held_done_count", dc, 1);
    // Start is low for one cycle, then rises again, and a new message begins
    @(negedge clk);
    start_v[0] = 1'b1;
    bq.push_back('{8'h48, 0, 1'b0});
    bq.push_back('{8'h6B, 1, 1'b1});
    dq.push_back(cyc + 1 + MSGT);
    @(negedge clk);
    chk("rearm_busy", int'(busy0), 1);
    chk("rearm_tx_start", int'(tx0), 0);
    start_v[0] = 1'b0;
    run(100, -1, bc, dc);
    chk("rearm_done_count", dc, 1);

    // MODE 1: continuous operation; start drops during the third message
    sel = 1;
    c = cyc;
    for (int k = 1; k <= 3; k++) begin
      bq.push_back('{8'h48, 0, 1'b0});
      bq.push_back('{8'h6B, 1, 1'b1});
      dq.push_back(c + 1 + k * MSGT);
    end
    start_v[1] = 1'b1;
    run(320, 199, bc, dc);
    chk("cont_busy_cycles", bc, 3 * MSGT);
    chk("cont_done_count", dc, 3);
    chk("cont_end_tx", int'(tx1), 1);
    chk("cont_end_busy", int'(busy1), 0);

    // MSG_LEN=1 with no gap
    sel = 2;
    bq.push_back('{8'h41, 0, 1'b0});
    dq.push_back(cyc + 1 + F * BAUD);
    start_v[2] = 1'b1;
    run(50, 0, bc, dc);
    chk("single_busy_cycles", bc, F * BAUD);
    chk("single_done_count", dc, 1);

    repeat (5) @(negedge clk);
    chk("frames_pending", bq.size(), 0);
    chk("dones_pending", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
